// File: rtl/conv1_layer1_dense_acc.sv
// conv1_layer1_dense_acc: 25-lane Q8.8 adder tree plus saturating multi-vector accumulator
module conv1_layer1_dense_acc #(
    parameter int LANES       = 25,
    parameter int VEC_PER_OUT = 4,
    parameter int ACC_W       = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic [16*LANES-1:0]   mult_res_w,
    input  logic                  mult_res_v_w,
    output logic [15:0]           sum_w,
    output logic                  sum_v_w,
    output logic                  sum_sat_w,
    output logic [7:0]            vec_cnt_w
);
    typedef enum logic {ACC_IDLE, ACC_RUN} acc_state_t;

    localparam logic [7:0]             VPO     = 8'(VEC_PER_OUT);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    logic signed [16:0] s1 [13];
    logic signed [17:0] s2 [7];
    logic signed [18:0] s3 [4];
    logic signed [19:0] s4 [2];
    logic signed [20:0] s5;
    logic [4:0]         v;

    acc_state_t              state, state_nx;
    logic signed [ACC_W-1:0] acc, acc_add, acc_nx;
    logic [7:0]              cnt, cnt_inc, cnt_nx;
    logic                    fire, pos, neg;

    // Five-stage sign-extending adder tree with a valid bit riding alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 13; i++) s1[i] <= '0;
            for (int i = 0; i < 7; i++) s2[i] <= '0;
            for (int i = 0; i < 4; i++) s3[i] <= '0;
            for (int i = 0; i < 2; i++) s4[i] <= '0;
            s5 <= '0;
            v  <= '0;
        end else if (!halt) begin
            for (int i = 0; i < 12; i++)
                s1[i] <= 17'($signed(mult_res_w[32*i +: 16])) + 17'($signed(mult_res_w[32*i+16 +: 16]));
            s1[12] <= 17'($signed(mult_res_w[16*24 +: 16]));
            for (int i = 0; i < 6; i++) s2[i] <= 18'(s1[2*i]) + 18'(s1[2*i+1]);
            s2[6] <= 18'(s1[12]);
            for (int i = 0; i < 3; i++) s3[i] <= 19'(s2[2*i]) + 19'(s2[2*i+1]);
            s3[3] <= 19'(s2[6]);
            for (int i = 0; i < 2; i++) s4[i] <= 20'(s3[2*i]) + 20'(s3[2*i+1]);
            s5 <= 21'(s4[0]) + 21'(s4[1]);
            v  <= {v[3:0], mult_res_v_w};
        end
    end

    // Accumulator next state: idle restarts the sum, the closing vector fires the output
    always_comb begin
        acc_add  = (state == ACC_IDLE ? '0 : acc) + ACC_W'(s5);
        cnt_inc  = cnt + 8'd1;
        fire     = v[4] && cnt_inc == VPO;
        acc_nx   = v[4] ? acc_add : acc;
        cnt_nx   = !v[4] ? cnt : fire ? 8'd0 : cnt_inc;
        state_nx = !v[4] ? state : fire ? ACC_IDLE : ACC_RUN;
        pos      = acc_add > SAT_MAX;
        neg      = acc_add < SAT_MIN;
    end

    // Accumulator state and saturated output register, frozen on halt
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC_IDLE;
            acc       <= '0;
            cnt       <= '0;
            sum_w     <= '0;
            sum_v_w   <= 1'b0;
            sum_sat_w <= 1'b0;
        end else if (!halt) begin
            state   <= state_nx;
            acc     <= acc_nx;
            cnt     <= cnt_nx;
            sum_v_w <= fire;
            if (fire) begin
                sum_w     <= pos ? 16'h7FFF : neg ? 16'h8000 : acc_add[15:0];
                sum_sat_w <= pos | neg;
            end
        end
    end

    assign vec_cnt_w = cnt;
endmodule

// File: tb/tb_conv1_layer1_dense_acc.sv
// tb_conv1_layer1_dense_acc: directed bench with a queue-based reference model for two group sizes
module tb_conv1_layer1_dense_acc;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              halt = 1'b0;
    logic              mv = 1'b0;
    logic [399:0]      mr = '0;
    logic [1:0][15:0]  sum_a;
    logic [1:0]        sv_a, sat_a;
    logic [1:0][7:0]   cnt_a;
    int                n_cmp = 0, n_bad = 0;
    bit                run = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instance 0 closes a group every vector, instance 1 every four vectors
    for (genvar g = 0; g < 2; g++) begin : g_i
        localparam int VPO = (g == 0) ? 1 : 4;
        int          due[$];
        int          val[$];
        int          tick, acc, cnt, s;
        logic [15:0] es;
        logic        ev, esat;

        conv1_layer1_dense_acc #(.VEC_PER_OUT(VPO)) dut (
            .clk(clk), .rst(rst), .halt(halt),
            .mult_res_w(mr), .mult_res_v_w(mv),
            .sum_w(sum_a[g]), .sum_v_w(sv_a[g]), .sum_sat_w(sat_a[g]), .vec_cnt_w(cnt_a[g])
        );

        // Model: each accepted vector's lane sum lands in the accumulator five unhalted edges later
        always @(posedge clk) begin
            if (rst) begin
                due.delete(); val.delete();
                tick = 0; acc = 0; cnt = 0; es = '0; ev = 1'b0; esat = 1'b0;
            end else if (!halt) begin
                tick++;
                ev = 1'b0;
                if (due.size() > 0 && due[0] == tick) begin
                    void'(due.pop_front());
                    acc = (cnt == 0 ? 0 : acc) + val.pop_front();
                    cnt++;
                    if (cnt == VPO) begin
                        ev = 1'b1;
                        cnt = 0;
                        esat = (acc > 32767) || (acc < -32768);
                        es = acc > 32767 ? 16'h7FFF : acc < -32768 ? 16'h8000 : acc[15:0];
                    end
                end
                if (mv) begin
                    s = 0;
                    for (int i = 0; i < 25; i++) s += $signed(mr[16*i +: 16]);
                    due.push_back(tick + 5);
                    val.push_back(s);
                end
            end
        end

        always @(negedge clk) begin
            if (run) begin
                chk($sformatf("i%0d sum_v_w", g), 32'(sv_a[g]), 32'(ev));
                chk($sformatf("i%0d sum_w", g), 32'(sum_a[g]), 32'(es));
                chk($sformatf("i%0d sum_sat_w", g), 32'(sat_a[g]), 32'(esat));
                chk($sformatf("i%0d vec_cnt_w", g), 32'(cnt_a[g]), 32'(cnt));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; mv = 1'b0; halt = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic valid);
        mv = valid;
        @(posedge clk); #1;
        mv = 1'b0;
    endtask

    task automatic set_all(input logic [15:0] x);
        for (int i = 0; i < 25; i++) mr[16*i +: 16] = x;
    endtask

    task automatic wait_pulse(input int inst, input int h_at, input int h_len,
                              output int n, output logic [7:0] prev);
        n = 0;
        prev = cnt_a[inst];
        forever begin
            @(negedge clk);
            n++;
            if (h_len > 0 && n == h_at) halt = 1'b1;
            if (h_len > 0 && n == h_at + h_len) halt = 1'b0;
            if (sv_a[inst]) return;
            prev = cnt_a[inst];
            if (n >= 40) begin
                n_cmp++; n_bad++;
                $display("FAIL pulse timeout on instance %0d: got no sum_v_w, required one", inst);
                halt = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        int          n;
        logic [7:0]  pc;
        logic [6:0]  pat;
        int          k;
        do_reset();
        run = 1'b1;
        chk("reset sum_w", 32'(sum_a[1]), 32'h0);
        chk("reset sum_v_w", 32'(sv_a[1]), 32'h0);
        chk("reset sum_sat_w", 32'(sat_a[1]), 32'h0);
        chk("reset vec_cnt_w", 32'(cnt_a[1]), 32'h0);

        set_all(16'h0100);
        send(1'b1);
        wait_pulse(0, 0, 0, n, pc);
        chk("single latency", 32'(n), 32'd6);
        chk("single sum", 32'(sum_a[0]), 32'h1900);
        chk("single sat", 32'(sat_a[0]), 32'h0);

        do_reset();
        mr = '0; mr[15:0] = 16'h0080;
        repeat (4) send(1'b1);
        wait_pulse(1, 0, 0, n, pc);
        chk("group latency", 32'(n), 32'd6);
        chk("group sum", 32'(sum_a[1]), 32'h0200);
        chk("group cnt before pulse", 32'(pc), 32'd3);
        chk("group cnt at pulse", 32'(cnt_a[1]), 32'd0);

        do_reset();
        set_all(16'h7FFF);
        repeat (4) send(1'b1);
        wait_pulse(1, 0, 0, n, pc);
        chk("pos sat sum", 32'(sum_a[1]), 32'h7FFF);
        chk("pos sat flag", 32'(sat_a[1]), 32'h1);
        set_all(16'h8000);
        repeat (4) send(1'b1);
        wait_pulse(1, 0, 0, n, pc);
        chk("neg sat sum", 32'(sum_a[1]), 32'h8000);
        chk("neg sat flag", 32'(sat_a[1]), 32'h1);
        for (int i = 0; i < 25; i++) mr[16*i +: 16] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
        repeat (4) send(1'b1);
        wait_pulse(1, 0, 0, n, pc);
        chk("mixed group sum", 32'(sum_a[1]), 32'h0400);
        chk("mixed group sat", 32'(sat_a[1]), 32'h0);
        chk("mixed single sum", 32'(sum_a[0]), 32'h0100);
        chk("mixed single sat", 32'(sat_a[0]), 32'h0);

        do_reset();
        set_all(16'h0100);
        send(1'b1);
        wait_pulse(0, 3, 3, n, pc);
        chk("halt latency", 32'(n), 32'd9);
        chk("halt sum", 32'(sum_a[0]), 32'h1900);
        send(1'b1);
        wait_pulse(0, 0, 0, n, pc);
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pulse held in halt", 32'(sv_a[0]), 32'h1);
        end
        halt = 1'b0;
        @(negedge clk);
        chk("pulse drops after halt", 32'(sv_a[0]), 32'h0);

        do_reset();
        mr = '0;
        pat = 7'b1100101;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) k++;
            mr[15:0] = 16'(16 * k);
            send(pat[i]);
        end
        wait_pulse(1, 0, 0, n, pc);
        chk("bubble latency", 32'(n), 32'd6);
        chk("bubble sum", 32'(sum_a[1]), 32'h00A0);

        do_reset();
        mr = '0; mr[15:0] = 16'h0100;
        repeat (2) send(1'b1);
        repeat (6) @(negedge clk);
        chk("partial cnt", 32'(cnt_a[1]), 32'd2);
        do_reset();
        chk("cnt after reset", 32'(cnt_a[1]), 32'd0);
        repeat (4) send(1'b1);
        wait_pulse(1, 0, 0, n, pc);
        chk("post-reset sum", 32'(sum_a[1]), 32'h0400);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
